// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate data cache that initiates the enable/write/ack line protocol.
// Optional hit/miss statistics counters are built when DCACHE_STATS_EN is defined.
module dcache_controller #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned WORD_W    = 32,
  parameter int unsigned LINE_W    = 256,
  parameter int unsigned NUM_LINES = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [WORD_W-1:0] cpu_data_i,
  output logic [WORD_W-1:0] cpu_data_o,
  output logic              cpu_stall_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [LINE_W-1:0] mem_data_i
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt_o,
  output logic [31:0]       miss_cnt_o
`endif
);

  localparam int unsigned BYTE_W = $clog2(LINE_W / 8);
  localparam int unsigned OFF_W  = $clog2(LINE_W / WORD_W);
  localparam int unsigned IDX_W  = $clog2(NUM_LINES);
  localparam int unsigned TAG_W  = ADDR_W - BYTE_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FETCH, FILL} state_t;

  state_t               state;
  logic [LINE_W-1:0]    line_data [NUM_LINES];
  logic [TAG_W-1:0]     line_tag  [NUM_LINES];
  logic [NUM_LINES-1:0] valid;
  logic [NUM_LINES-1:0] dirty;

  logic [OFF_W-1:0]     off;
  logic [IDX_W-1:0]     idx;
  logic [TAG_W-1:0]     tag;
  logic                 hit;
  logic                 unused_addr_bits;

  assign off = cpu_addr_i[BYTE_W-1 -: OFF_W];
  assign idx = cpu_addr_i[BYTE_W +: IDX_W];
  assign tag = cpu_addr_i[ADDR_W-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[BYTE_W-OFF_W-1:0];

  // Only IDLE may hit: during FILL the line is still being written.
  assign hit         = cpu_req_i && (state == IDLE) && valid[idx] && (line_tag[idx] == tag);
  assign cpu_stall_o = cpu_req_i && !hit;
  assign cpu_data_o  = line_data[idx][off*WORD_W +: WORD_W];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      valid        <= '0;
      dirty        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            if (cpu_we_i) begin
              line_data[idx][off*WORD_W +: WORD_W] <= cpu_data_i;
              dirty[idx]                           <= 1'b1;
            end
          end else if (cpu_req_i) begin
            mem_enable_o <= 1'b1;
            if (valid[idx] && dirty[idx]) begin
              state       <= WB;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {line_tag[idx], idx, {BYTE_W{1'b0}}};
              mem_data_o  <= line_data[idx];
            end else begin
              state       <= FETCH;
              mem_write_o <= 1'b0;
              mem_addr_o  <= {tag, idx, {BYTE_W{1'b0}}};
            end
          end
        end
        WB: begin
          if (mem_ack_i) begin
            state       <= FETCH;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {tag, idx, {BYTE_W{1'b0}}};
          end
        end
        FETCH: begin
          if (mem_ack_i) begin
            state        <= FILL;
            mem_enable_o <= 1'b0;
          end
        end
        FILL: begin
          line_data[idx] <= mem_data_i;
          line_tag[idx]  <= tag;
          valid[idx]     <= 1'b1;
          dirty[idx]     <= 1'b0;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic replay;

  // The first IDLE cycle after FILL is the stalled request completing, not a new hit.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
      replay     <= 1'b0;
    end else begin
      if (state == FILL) begin
        replay <= 1'b1;
      end else if (state == IDLE) begin
        replay <= 1'b0;
      end
      if (hit && !replay && (hit_cnt_o != '1)) begin
        hit_cnt_o <= hit_cnt_o + 1'b1;
      end
      if ((state == IDLE) && cpu_req_i && !hit && (miss_cnt_o != '1)) begin
        miss_cnt_o <= miss_cnt_o + 1'b1;
      end
    end
  end
`else
  // Without statistics the cache carries no counter state.
`endif

endmodule
